// File: rtl/circular_dma_mm2s.sv
// Circular-buffer MM2S DMA: reads a DDR ring via AXI4 bursts and forwards beats as AXI-Stream.
// Tracks its own read offset against a producer-supplied write offset.
module circular_dma_mm2s #(
   parameter int unsigned C_ADDR_WIDTH = 32,
   parameter int unsigned C_AXIS_WIDTH = 64,
   parameter int unsigned C_MAX_BURST  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [C_ADDR_WIDTH-1:0] buf_base,
   input  logic [31:0]             buf_size,
   input  logic [31:0]             wr_ptr,
   output logic [31:0]             rd_ptr,
   output logic                    busy,
   output logic                    irq,
   output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [C_AXIS_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rlast,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   output logic [C_AXIS_WIDTH-1:0] m_axis_mm2s_tdata,
   output logic                    m_axis_mm2s_tlast,
   output logic                    m_axis_mm2s_tvalid,
   input  logic                    m_axis_mm2s_tready
);

   localparam int unsigned BeatBytes  = C_AXIS_WIDTH / 8;
   localparam int unsigned BeatShift  = $clog2(BeatBytes);
   localparam int unsigned ChunkBytes = C_MAX_BURST * BeatBytes;

   typedef enum logic [1:0] {
      StIdle,
      StAddr,
      StData,
      StHalt
   } state_e;

   state_e                  state_q, state_d;
   logic [31:0]             rd_ptr_q, rd_ptr_d;
   logic [C_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [7:0]              arlen_q, arlen_d;
   logic                    irq_q, irq_d;

   logic [31:0] fill_bytes;
   logic [31:0] avail_words;
   logic [31:0] bound_words;
   logic [31:0] len_words;
   logic [31:0] next_ptr;
   logic        beat_hs;
   logic        beat_err;

   // Burst sizing: limited by max burst, data available, and the next chunk boundary.
   // The chunk boundary also covers the ring end and 4 KB since base/size are chunk aligned.
   always_comb begin
      if (wr_ptr >= rd_ptr_q) begin
         fill_bytes = wr_ptr - rd_ptr_q;
      end else begin
         fill_bytes = wr_ptr + buf_size - rd_ptr_q;
      end
      avail_words = fill_bytes >> BeatShift;
      bound_words = (32'(ChunkBytes) - (rd_ptr_q & 32'(ChunkBytes - 1))) >> BeatShift;
      len_words   = 32'(C_MAX_BURST);
      if (avail_words < len_words) begin
         len_words = avail_words;
      end
      if (bound_words < len_words) begin
         len_words = bound_words;
      end
      next_ptr = rd_ptr_q + ((32'(arlen_q) + 32'd1) << BeatShift);
      if (next_ptr == buf_size) begin
         next_ptr = '0;
      end
   end

   assign beat_hs  = (state_q == StData) & m_axi_rvalid & m_axis_mm2s_tready;
   assign beat_err = beat_hs & (m_axi_rresp != 2'b00);

   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      araddr_d = araddr_q;
      arlen_d  = arlen_q;
      irq_d    = irq_q;
      case (state_q)
         StIdle: begin
            if (!enable) begin
               rd_ptr_d = '0;
            end else if (avail_words != 32'd0) begin
               araddr_d = buf_base + C_ADDR_WIDTH'(rd_ptr_q);
               arlen_d  = 8'(len_words - 32'd1);
               state_d  = StAddr;
            end
         end
         StAddr: begin
            if (m_axi_arready) begin
               state_d = StData;
            end
         end
         StData: begin
            if (beat_err) begin
               irq_d = 1'b1;
            end
            // irq_q can only be set by this burst, so it doubles as the burst error flag.
            if (beat_hs && m_axi_rlast) begin
               if (irq_q || beat_err) begin
                  state_d = StHalt;
               end else begin
                  rd_ptr_d = next_ptr;
                  state_d  = StIdle;
               end
            end
         end
         StHalt: begin
            if (!enable) begin
               irq_d    = 1'b0;
               rd_ptr_d = '0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         rd_ptr_q <= '0;
         araddr_q <= '0;
         arlen_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         araddr_q <= araddr_d;
         arlen_q  <= arlen_d;
         irq_q    <= irq_d;
      end
   end

   assign rd_ptr        = rd_ptr_q;
   assign irq           = irq_q;
   assign busy          = (state_q == StAddr) || (state_q == StData);
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arvalid = (state_q == StAddr);

   assign m_axi_rready       = (state_q == StData) & m_axis_mm2s_tready;
   assign m_axis_mm2s_tvalid = (state_q == StData) & m_axi_rvalid;
   assign m_axis_mm2s_tlast  = (state_q == StData) & m_axi_rlast;
   assign m_axis_mm2s_tdata  = m_axi_rdata;

endmodule

// File: tb/tb_circular_dma_mm2s.sv
// Bench for circular_dma_mm2s: directed table of bursts, error/stall/reset sequences,
// and randomized ring traffic checked against an arithmetic ring model.
module tb_circular_dma_mm2s;

   localparam logic [31:0] Base = 32'h1000_0000;
   localparam logic [31:0] Size = 32'h0000_0400;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [31:0] buf_base;
   logic [31:0] buf_size;
   logic [31:0] wr_ptr;
   logic [31:0] rd_ptr;
   logic        busy;
   logic        irq;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic        arvalid;
   logic        arready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [63:0] tdata;
   logic        tlast;
   logic        tvalid;
   logic        tready;

   int checks;
   int failures;
   logic [31:0] m_rd;

   circular_dma_mm2s #(
      .C_ADDR_WIDTH(32),
      .C_AXIS_WIDTH(64),
      .C_MAX_BURST (16)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .enable            (enable),
      .buf_base          (buf_base),
      .buf_size          (buf_size),
      .wr_ptr            (wr_ptr),
      .rd_ptr            (rd_ptr),
      .busy              (busy),
      .irq               (irq),
      .m_axi_araddr      (araddr),
      .m_axi_arlen       (arlen),
      .m_axi_arvalid     (arvalid),
      .m_axi_arready     (arready),
      .m_axi_rdata       (rdata),
      .m_axi_rresp       (rresp),
      .m_axi_rlast       (rlast),
      .m_axi_rvalid      (rvalid),
      .m_axi_rready      (rready),
      .m_axis_mm2s_tdata (tdata),
      .m_axis_mm2s_tlast (tlast),
      .m_axis_mm2s_tvalid(tvalid),
      .m_axis_mm2s_tready(tready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a ^ 32'hA5A5_0000, ~a};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_rd_ptr", rd_ptr, 0);
      check("rst_busy", busy, 0);
      check("rst_irq", irq, 0);
      check("rst_arvalid", arvalid, 0);
      check("rst_rready", rready, 0);
      check("rst_tvalid", tvalid, 0);
      check("rst_araddr", araddr, 0);
      check("rst_arlen", arlen, 0);
   endtask

   task automatic idle_check(input int cycles);
      bit any;
      any = 1'b0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         #1;
         any = any | arvalid;
      end
      check("idle_no_ar", 64'(any), 0);
   endtask

   task automatic restart();
      @(negedge clk);
      enable = 1'b0;
      wr_ptr = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("restart_rd_ptr", rd_ptr, 0);
      check("restart_busy", busy, 0);
      enable = 1'b1;
      m_rd   = '0;
   endtask

   // Acts as AXI slave for one expected burst and checks the stream side beat by beat.
   task automatic do_burst(input logic [31:0] addr, input int alen, input int err_beat,
                           input int stall_beat, input int stall_cyc, input bit rnd,
                           input int abort_beat, input logic [31:0] rd_before);
      bit          seen;
      logic [63:0] d;
      int          gap;
      int          st;
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clk);
         #1;
         seen = arvalid;
      end
      check("ar_issued", 64'(seen), 1);
      if (!seen) return;
      check("busy_addr", busy, 1);
      check("araddr", araddr, addr);
      check("arlen", arlen, 64'(alen));
      if (rnd) begin
         gap = $urandom_range(0, 2);
         for (int k = 0; k < gap; k++) begin
            @(negedge clk);
            #1;
            check("araddr_hold", araddr, addr);
         end
      end
      @(negedge clk);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      #1;
      check("arvalid_drop", arvalid, 0);
      for (int i = 0; i <= alen; i++) begin
         d   = mem_word(addr + 32'(i * 8));
         gap = rnd ? int'($urandom_range(0, 1)) : 0;
         for (int k = 0; k < gap; k++) begin
            @(negedge clk);
            rvalid = 1'b0;
            tready = 1'b1;
            #1;
            check("tvalid_gap", tvalid, 0);
         end
         st = (i == stall_beat) ? stall_cyc : (rnd ? int'($urandom_range(0, 1)) : 0);
         for (int k = 0; k < st; k++) begin
            @(negedge clk);
            rvalid = 1'b1;
            rdata  = d;
            rlast  = (i == alen);
            rresp  = 2'b00;
            tready = 1'b0;
            #1;
            check("rready_stall", rready, 0);
            check("tvalid_stall", tvalid, 1);
            check("tdata_stall", tdata, d);
            check("rd_ptr_midburst", rd_ptr, rd_before);
         end
         @(negedge clk);
         rvalid = 1'b1;
         rdata  = d;
         rlast  = (i == alen);
         rresp  = (i == err_beat) ? 2'b10 : 2'b00;
         tready = 1'b1;
         if (i == abort_beat) begin
            rst_n = 1'b0;
            return;
         end
         #1;
         check("rready", rready, 1);
         check("tvalid", tvalid, 1);
         check("tdata", tdata, d);
         check("tlast", tlast, 64'(i == alen));
         check("irq_beat", irq, 64'(err_beat >= 0 && i > err_beat));
      end
      @(negedge clk);
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      #1;
      check("busy_done", busy, 0);
      check("irq_done", irq, 64'(err_beat >= 0));
   endtask

   // Ring model: issue bursts until the read offset catches up with target.
   task automatic drain(input logic [31:0] target, input bit rnd);
      int unsigned avail;
      int unsigned bound;
      int unsigned len;
      int          guard;
      int          sb;
      wr_ptr = target;
      guard  = 0;
      while (m_rd != target && guard < 64) begin
         avail = ((target + Size - m_rd) % Size) / 8;
         bound = (128 - (m_rd % 128)) / 8;
         len   = 16;
         if (avail < len) len = avail;
         if (bound < len) len = bound;
         sb = rnd ? int'($urandom_range(0, len - 1)) : -1;
         do_burst(Base + m_rd, int'(len) - 1, -1, sb, 3, rnd, -1, m_rd);
         m_rd = (m_rd + len * 8) % Size;
         check("rd_ptr_model", rd_ptr, m_rd);
         guard++;
      end
      idle_check(3);
   endtask

   typedef struct {
      bit          restart;
      bit          pre;
      logic [31:0] pre_wr;
      logic [31:0] wr;
      logic [31:0] addr;
      int          alen;
      logic [31:0] rd;
   } vec_t;

   vec_t vecs[6];

   initial begin
      checks   = 0;
      failures = 0;
      m_rd     = '0;
      rst_n    = 1'b0;
      enable   = 1'b0;
      buf_base = Base;
      buf_size = Size;
      wr_ptr   = '0;
      arready  = 1'b0;
      rdata    = '0;
      rresp    = 2'b00;
      rlast    = 1'b0;
      rvalid   = 1'b0;
      tready   = 1'b1;

      vecs[0] = '{1'b1, 1'b0, 32'h0,   32'h80, Base,            15, 32'h80};
      vecs[1] = '{1'b1, 1'b0, 32'h0,   32'h28, Base,            4,  32'h28};
      vecs[2] = '{1'b0, 1'b0, 32'h0,   32'h90, Base + 32'h28,   10, 32'h80};
      vecs[3] = '{1'b0, 1'b0, 32'h0,   32'h90, Base + 32'h80,   1,  32'h90};
      vecs[4] = '{1'b0, 1'b1, 32'h3C0, 32'h40, Base + 32'h3C0,  7,  32'h0};
      vecs[5] = '{1'b0, 1'b0, 32'h0,   32'h40, Base,            7,  32'h40};

      @(negedge clk);
      @(negedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;

      foreach (vecs[v]) begin
         if (vecs[v].restart) restart();
         if (vecs[v].pre) drain(vecs[v].pre_wr, 1'b0);
         wr_ptr = vecs[v].wr;
         do_burst(vecs[v].addr, vecs[v].alen, -1, -1, 0, 1'b0, -1, m_rd);
         check("vec_rd_ptr", rd_ptr, vecs[v].rd);
         m_rd = vecs[v].rd;
         if (vecs[v].rd == vecs[v].wr) idle_check(4);
      end

      // Stream backpressure: tready low 10 cycles in the middle of a burst.
      restart();
      wr_ptr = 32'h80;
      do_burst(Base, 15, -1, 5, 10, 1'b0, -1, 32'h0);
      check("stall_rd_ptr", rd_ptr, 32'h80);

      // Error on beat 3 of a 16-beat burst: data forwarded, offset frozen, halt until disable.
      wr_ptr = 32'h100;
      do_burst(Base + 32'h80, 15, 2, -1, 0, 1'b0, -1, 32'h80);
      check("err_rd_ptr", rd_ptr, 32'h80);
      idle_check(20);
      check("err_irq_sticky", irq, 1);
      @(negedge clk);
      enable = 1'b0;
      wr_ptr = '0;
      @(negedge clk);
      #1;
      check("halt_irq_clear", irq, 0);
      check("halt_rd_ptr_clear", rd_ptr, 0);
      enable = 1'b1;
      m_rd   = '0;

      // Reset in the middle of the data phase.
      restart();
      wr_ptr = 32'h80;
      do_burst(Base, 15, -1, -1, 0, 1'b0, 3, 32'h0);
      @(negedge clk);
      #1;
      check_reset_outputs();
      rvalid = 1'b0;
      rlast  = 1'b0;
      rst_n  = 1'b1;
      m_rd   = '0;
      do_burst(Base, 15, -1, -1, 0, 1'b0, -1, 32'h0);
      check("post_reset_rd_ptr", rd_ptr, 32'h80);
      m_rd = 32'h80;

      // Randomized ring traffic with random handshake timing.
      restart();
      for (int n = 0; n < 12; n++) begin
         drain(32'($urandom_range(0, 127)) * 32'd8, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/circular_dma_mm2s.md
Name: circular_dma_mm2s

Overview:
Memory-to-stream counterpart of the S2MM circular DMA. It reads a circular buffer in DDR through an AXI4 read master and emits the data as AXI-Stream. The producer's write offset is supplied as an input. The block tracks its own read offset and publishes it to the register file, so software or a peer writer can treat the buffer as a ring.

Parameters:
C_ADDR_WIDTH, 32, AXI address width.
C_AXIS_WIDTH, 64, stream/AXI data width in bits; bytes per beat B = C_AXIS_WIDTH/8.
C_MAX_BURST, 16, max beats per AR burst; power of two, ≤256.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
enable  in  1  run control
buf_base  in  C_ADDR_WIDTH  ring base; aligned to C_MAX_BURST*B
buf_size  in  32  ring size in bytes; nonzero multiple of C_MAX_BURST*B
wr_ptr  in  32  producer byte offset, multiple of B, < buf_size
rd_ptr  out  32  consumer byte offset
busy  out  1  burst in flight
irq  out  1  sticky read-error flag
m_axi_araddr  out  C_ADDR_WIDTH  burst address
m_axi_arlen  out  8  beats-1
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address ready
m_axi_rdata  in  C_AXIS_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat
m_axi_rvalid  in  1  data valid
m_axi_rready  out  1  data ready
m_axis_mm2s_tdata  out  C_AXIS_WIDTH  stream data
m_axis_mm2s_tlast  out  1  last beat of burst
m_axis_mm2s_tvalid  out  1  stream valid
m_axis_mm2s_tready  in  1  stream ready

Behaviour:
- Reset: state IDLE; rd_ptr=0, busy=0, irq=0, arvalid=0, rready=0, tvalid=0, araddr=0, arlen=0. Reset mid-burst abandons the burst; the system resets the interconnect together with this block.
- States: IDLE, ADDR, DATA, HALT. At most one burst outstanding.
- avail words = ((wr_ptr − rd_ptr) mod buf_size)/B. rd_ptr==wr_ptr means empty; the producer never fills the ring completely.
- IDLE: if enable=0, hold rd_ptr at 0. If enable=1 and avail>0: len = min(C_MAX_BURST, avail, words to next C_MAX_BURST*B boundary). Register araddr=buf_base+rd_ptr and arlen=len−1, then go to ADDR (arvalid=1, busy=1). One-cycle decision latency.
- ADDR: hold araddr/arlen stable until arready, then go to DATA.
- DATA: combinational pass-through. tvalid=rvalid, tdata=rdata, tlast=rlast, rready=tready. No beat is dropped or duplicated.
- On the rlast handshake: rd_ptr += len*B, wrapping to 0 when the result equals buf_size. busy=0. Go to IDLE, or to HALT if an error occurred in the burst.
- Errors: rresp≠OKAY on any beat sets irq=1. The burst still completes and data is still forwarded. rd_ptr does not advance for an errored burst. Next state is HALT.
- HALT: no AR issued. When enable=0: clear irq, set rd_ptr=0, go to IDLE.
- enable deasserted mid-burst: the burst finishes normally and rd_ptr advances; then IDLE clears rd_ptr.
- wr_ptr may change at any time. It is sampled only in IDLE.
- Because the burst boundary term is applied, bursts never cross a 4 KB boundary or the ring end.
- Tied in the wrapper: arsize=log2(B), arburst=INCR, arprot/arcache/aruser from parameters.

Test Plan:
All scenarios use B=8, C_MAX_BURST=16, buf_base=0x10000000, buf_size=0x400, enable=1, tready=1.
1. wr_ptr=0x80 → one AR: araddr 0x10000000, arlen 15. 16 stream beats, tlast on beat 16. rd_ptr=0x80, then idle.
2. wr_ptr=0x28 → araddr 0x10000000, arlen 4; rd_ptr=0x28. Then wr_ptr=0x90 → araddr 0x10000028, arlen 10 (stops at the 0x80 boundary); rd_ptr=0x80. Then araddr 0x10000080, arlen 1; rd_ptr=0x90.
3. Wrap: rd_ptr reaches 0x3C0, wr_ptr=0x40 → araddr 0x100003C0, arlen 7, rd_ptr=0x000. Then araddr 0x10000000, arlen 7, rd_ptr=0x40.
4. tready held low 10 cycles mid-burst → rready low for the same cycles. Beat order and count are exact; rd_ptr updates only after rlast.
5. rresp=2'b10 on beat 3 of a 16-beat burst → irq=1 from the next cycle. All 16 beats are forwarded, rd_ptr is unchanged, no further AR. enable=0 → irq=0, rd_ptr=0.
6. rst_n=0 during DATA → the next cycle shows all outputs at reset values; after release with enable=1, the first AR is at 0x10000000.
